// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable word width, slave selects, SCK divider,
// CPOL/CPHA, bit order and multi-word bursts with chip-select held between words.
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8,
  parameter int SS_GAP = 2,
  localparam int SW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SW-1:0]     tx_ss_sel,
  input  logic              tx_last,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n,
  output logic              spi_lead,
  output logic              spi_trail
);

  localparam int TW = $clog2(2*DATA_W + 1);
  localparam int BW = $clog2(DATA_W);
  localparam int GW = $clog2(SS_GAP + 1);
  localparam logic [TW-1:0] TOG_END = TW'(2*DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    cnt_q, div_q;
  logic [TW-1:0]       tog_q;
  logic [GW-1:0]       gap_q;
  logic [DATA_W-1:0]   tx_q, rx_sh_q, rx_data_q;
  logic                last_q, cpha_q, lsb_q;
  logic                sck_q, mosi_q, rdy_q;
  logic                rx_valid_q, done_q, lead_q, trail_q;
  logic [NUM_SS-1:0]   ss_n_q;

  logic [TW-1:0]       tog_n;
  logic [BW-1:0]       pos_n;
  logic                hp_end, smp_n;
  logic [DATA_W-1:0]   rx_nxt;
  logic [DIV_W-1:0]    div_in;

  function automatic logic bit_at(input logic [DATA_W-1:0] w, input logic [BW-1:0] pos,
                                  input logic lsb);
    logic [BW-1:0] idx;
    idx = lsb ? pos : (BW'(DATA_W-1) - pos);
    return w[idx];
  endfunction

  // Out-of-range selects leave every line high; the bus is still clocked.
  function automatic logic [NUM_SS-1:0] ss_dec(input logic [SW-1:0] sel);
    logic [NUM_SS-1:0] s;
    s = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (int'(sel) == i) s[i] = 1'b0;
    return s;
  endfunction

  assign tog_n  = tog_q + TW'(1);
  assign pos_n  = BW'(tog_n >> 1);
  assign hp_end = (cnt_q == div_q - DIV_W'(1));
  // Odd toggles are leading; the sampling edge is leading for cpha=0, trailing for cpha=1.
  assign smp_n  = tog_n[0] ^ cpha_q;
  assign rx_nxt = lsb_q ? {miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso};
  assign div_in = (cfg_div == '0) ? DIV_W'(1) : cfg_div;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_W'(1);
      tog_q      <= '0;
      gap_q      <= '0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      last_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      rdy_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      lead_q     <= 1'b0;
      trail_q    <= 1'b0;
      ss_n_q     <= '1;
    end else begin
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      lead_q     <= 1'b0;
      trail_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          sck_q  <= cfg_cpol;
          mosi_q <= 1'b0;
          rdy_q  <= 1'b1;
          if (tx_valid && rdy_q) begin
            tx_q    <= tx_data;
            last_q  <= tx_last;
            cpha_q  <= cfg_cpha;
            lsb_q   <= cfg_lsb_first;
            div_q   <= div_in;
            ss_n_q  <= ss_dec(tx_ss_sel);
            if (!cfg_cpha) mosi_q <= bit_at(tx_data, '0, cfg_lsb_first);
            cnt_q   <= '0;
            tog_q   <= '0;
            rdy_q   <= 1'b0;
            state_q <= SETUP;
          end
        end
        SETUP, XFER: begin
          if (state_q == XFER && tog_q == TOG_END) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= rx_sh_q;
            cnt_q      <= '0;
            gap_q      <= '0;
            if (last_q) begin
              ss_n_q  <= '1;
              done_q  <= 1'b1;
              state_q <= GAP;
            end else begin
              rdy_q   <= 1'b1;
              state_q <= HOLD;
            end
          end else if (hp_end) begin
            cnt_q   <= '0;
            sck_q   <= ~sck_q;
            tog_q   <= tog_n;
            lead_q  <= tog_n[0];
            trail_q <= ~tog_n[0];
            state_q <= XFER;
            if (smp_n)                rx_sh_q <= rx_nxt;
            else if (tog_n != TOG_END) mosi_q <= bit_at(tx_q, pos_n, lsb_q);
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        HOLD: begin
          // Burst continuation: ss_n and the frozen configuration carry over.
          if (tx_valid && rdy_q) begin
            tx_q    <= tx_data;
            last_q  <= tx_last;
            if (!cpha_q) mosi_q <= bit_at(tx_data, '0, lsb_q);
            cnt_q   <= '0;
            tog_q   <= '0;
            rdy_q   <= 1'b0;
            state_q <= SETUP;
          end
        end
        GAP: begin
          if (hp_end) begin
            cnt_q <= '0;
            if (gap_q == GW'(SS_GAP-1)) begin
              state_q <= IDLE;
              rdy_q   <= 1'b1;
              mosi_q  <= 1'b0;
            end else begin
              gap_q <= gap_q + GW'(1);
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready  = rdy_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign sck       = sck_q;
  assign mosi      = mosi_q;
  assign ss_n      = ss_n_q;
  assign spi_lead  = lead_q;
  assign spi_trail = trail_q;

endmodule
